ublock_rc_gen: RTL
==================

# ublock_rc_gen

Parametrised round-constant generator and round sequencer for the uBlock datapath. It is the successor of the fixed 8-bit round LFSR. It generalises the register width, feedback taps, seed and round count. It adds an explicit start/busy/done handshake, an encrypt/decrypt mode with an inverse LFSR step, and a round index counter that drives the first/last-round flags. It sits beside the round function and key schedule, and feeds them `rc` and the round control flags.

## Interface
- `W`, 8: LFSR width in bits; must be ≥ 3.
- `TAPS`, 8'h63: feedback mask. Forward feedback is the XOR of `state & TAPS`. `TAPS[0]` must be 1.
- `SEED`, 8'h36: encryption start state. Must be nonzero.
- `ROUNDS`, 16: number of rounds. Must be ≥ 2.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `start` in 1: begin a run. Sampled only in IDLE.
- `decrypt` in 1: mode, sampled together with `start`. 0 = forward sequence, 1 = reverse sequence.
- `advance` in 1: step to the next round. Honoured only in RUN.
- `rc` out W: current round constant, registered.
- `round_idx` out $clog2(ROUNDS): index of the current round constant in the forward order, registered.
- `first_round` out 1: current round is the first one processed in this run.
- `last_round` out 1: current round is the last one processed in this run.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse after the last round is consumed.

## Operation
- Forward step: `next[W-1] = ^(s & TAPS)`, and `next[i] = s[i+1]` for i < W-1.
- Inverse step: `prev[i+1] = s[i]` for i < W-1, and `prev[0] = s[W-1] ^ ^(s[W-2:0] & TAPS[W-1:1])`.
- `LAST_SEED` is `SEED` after ROUNDS-1 forward steps. It is computed at elaboration by a constant function; no runtime precomputation.
- FSM states and transitions:
  - IDLE → RUN on `start`.
    - Encrypt: load `rc = SEED`, `round_idx = 0`.
    - Decrypt: load `rc = LAST_SEED`, `round_idx = ROUNDS-1`. The mode bit is latched.
  - RUN, `advance` and not `last_round`:
    - Encrypt: forward step, `round_idx`+1.
    - Decrypt: inverse step, `round_idx`−1.
  - RUN, `advance` and `last_round` → DONE. `rc` and `round_idx` hold.
  - DONE → IDLE unconditionally after one cycle. `done` = 1 only in DONE.
- Flags are combinational from registered state, gated by `busy`:
  - Encrypt: `first_round` = (idx == 0); `last_round` = (idx == ROUNDS-1).
  - Decrypt: `first_round` = (idx == ROUNDS-1); `last_round` = (idx == 0).
- Boundary rules:
  - `start` in RUN or DONE: ignored. Mode does not change mid-run.
  - `advance` in IDLE or DONE: ignored.
  - `start` and `advance` in the same IDLE cycle: load only, no step.
  - `round_idx` never wraps. It is bounded to [0, ROUNDS-1] by the FSM.
  - `rst` low in any state, including mid-run, takes priority over everything. Next cycle is IDLE with reset values.

## Timing
- Reset values:
  - `rc = SEED`, `round_idx = 0`.
  - `busy = 0`, `done = 0`, `first_round = 0`, `last_round = 0`.
- Load: `start` at cycle t gives `busy = 1` at t+1, with the first constant on `rc` and `first_round = 1`.
- Step latency: `advance` at t gives the new `rc`/`round_idx` at t+1.
- Run length: a run takes exactly ROUNDS-1 stepping advances plus 1 terminating advance.
  - `advance` at t with `last_round` gives `busy = 0` and `done = 1` at t+1, and IDLE at t+2.
  - Earliest next `start` accepted is at t+2.
- Back-to-back `advance` every cycle is supported. Minimum run is ROUNDS+2 cycles from `start` to IDLE.

## Structure
- Package `ublock_pkg` holds:
  - default `W`, `TAPS`, `SEED`, `ROUNDS` constants;
  - FSM state encoding `rc_state_t` (IDLE, RUN, DONE);
  - constant function `lfsr_last_seed(seed, taps, n)`.
- Sub-module `lfsr_step`: purely combinational, parametrised by `W` and `TAPS`. Inputs are state and direction; output is the next state. Instantiated once, with direction = latched mode.
- Top level holds the FSM, the `rc` and `round_idx` registers, and the flag logic.

## Test plan
- Reset: hold `rst` low 2 cycles, then release → `rc` = 0x36, `round_idx` = 0, `busy`/`done`/flags all 0.
- Encrypt steps: `start` with `decrypt` = 0, then 3 `advance` → `rc` sequence 0x36, 0x1B, 0x0D, 0x86. `first_round` high only while `rc` = 0x36.
- Full runs:
  - Encrypt run of 16 advances: `last_round` high only at `round_idx` 15; `done` pulses once, one cycle after the 16th advance; back to IDLE.
  - Decrypt run: first `rc` = `LAST_SEED`, `round_idx` 15. The `rc` sequence is the exact reverse of the encrypt run and includes 0x86 → 0x0D → 0x1B → 0x36. `last_round` is high at idx 0.
- Illegal/simultaneous events:
  - `start` pulsed at idx 5 of a run: no effect on `rc`, mode or index.
  - `advance` in IDLE: `rc` stays 0x36.
  - `start` and `advance` in the same IDLE cycle: `rc` = 0x36, idx 0.
- Reset mid-run: `rst` low at idx 7 → next cycle is IDLE with `rc` = 0x36 and no `done` pulse. A new `start` then runs normally.

Source files
------------

// File: rtl/ublock_pkg.sv
// ---------------------------------------------------------------------------
// ublock_pkg
//
// Shared definitions for the uBlock round-constant generator:
//   - default LFSR width, feedback taps, seed and round count
//   - rc_state_t, the sequencer state encoding (IDLE, RUN, DONE)
//   - lfsr_last_seed(), a constant function that runs the forward LFSR
//     step n times from a seed. The top level uses it at elaboration to
//     find the start state of a decrypt run.
// ---------------------------------------------------------------------------
package ublock_pkg;

    localparam int         DEF_W      = 8;
    localparam logic [7:0] DEF_TAPS   = 8'h63;
    localparam logic [7:0] DEF_SEED   = 8'h36;
    localparam int         DEF_ROUNDS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } rc_state_t;

    // Forward-step the LFSR n times. The work is done in a 64-bit
    // container so that one function serves any width up to 64. Bits
    // above the active width are masked off after every step.
    function automatic logic [63:0] lfsr_last_seed(
        input logic [63:0] seed,
        input logic [63:0] taps,
        input int          n,
        input int          w = DEF_W
    );
        logic [63:0] s;
        logic [63:0] mask;
        logic        fb;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        s    = seed & mask;
        for (int i = 0; i < n; i++) begin
            fb = ^(s & taps & mask);
            s  = ((s >> 1) | (64'(fb) << (w - 1))) & mask;
        end
        return s;
    endfunction

endpackage

// File: rtl/ublock_rc_gen_if.sv
// ---------------------------------------------------------------------------
// ublock_rc_gen_if
//
// Control and round-constant bundle between the round sequencer and the
// logic that uses it.
//   master (datapath / controller side):
//     out start, decrypt, advance
//     in  rc, round_idx, first_round, last_round, busy, done
//   slave (ublock_rc_gen):
//     the same signals with the directions reversed
// ---------------------------------------------------------------------------
interface ublock_rc_gen_if
    import ublock_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int ROUNDS = DEF_ROUNDS
);

    localparam int IDXW = $clog2(ROUNDS);

    logic            start;
    logic            decrypt;
    logic            advance;
    logic [W-1:0]    rc;
    logic [IDXW-1:0] round_idx;
    logic            first_round;
    logic            last_round;
    logic            busy;
    logic            done;

    modport master (
        output start, decrypt, advance,
        input  rc, round_idx, first_round, last_round, busy, done
    );

    modport slave (
        input  start, decrypt, advance,
        output rc, round_idx, first_round, last_round, busy, done
    );

endinterface

// File: rtl/ublock_rc_gen_lfsr_step.sv
// ---------------------------------------------------------------------------
// lfsr_step
//
// One combinational LFSR step in either direction.
//   state_i   : current LFSR state
//   inverse_i : 0 = forward step, 1 = inverse step
//   next_o    : state after one step in the chosen direction
//
// In the forward step the register shifts right and the parity of the
// tapped bits enters at the MSB. The inverse step shifts left. The bit
// that fell out at position 0 is recovered from the old feedback value,
// which now sits in the MSB. TAPS[0] must be 1 for the inverse step to
// exist.
// ---------------------------------------------------------------------------
module lfsr_step
    import ublock_pkg::*;
#(
    parameter int         W    = DEF_W,
    parameter logic [W-1:0] TAPS = W'(DEF_TAPS)
) (
    input  logic [W-1:0] state_i,
    input  logic         inverse_i,
    output logic [W-1:0] next_o
);

    logic fwd_fb;
    logic inv_fb;

    assign fwd_fb = ^(state_i & TAPS);

    // The old MSB-side parity is known apart from the contribution of the
    // lost bit 0, because TAPS[0] = 1. XOR out the remaining tapped bits,
    // which have all moved down by one place.
    assign inv_fb = state_i[W-1] ^ (^(state_i[W-2:0] & TAPS[W-1:1]));

    // Pick the direction. The datapath holds it steady for a whole run.
    always_comb begin
        if (inverse_i) begin
            next_o = {state_i[W-2:0], inv_fb};
        end else begin
            next_o = {fwd_fb, state_i[W-1:1]};
        end
    end

endmodule

// File: rtl/ublock_rc_gen.sv
// ---------------------------------------------------------------------------
// ublock_rc_gen
//
// Round-constant generator and round sequencer for the uBlock datapath.
//   clk : clock, rising edge
//   rst : synchronous reset, active low
//   bus : ublock_rc_gen_if.slave
//           start/decrypt   begin a run in the chosen mode (sampled in IDLE)
//           advance         move to the next round (honoured in RUN)
//           rc, round_idx   current round constant and its forward index
//           first_round,
//           last_round      position flags for the current run
//           busy            high while a run is active
//           done            one-cycle pulse after the last round
//
// An encrypt run walks the forward LFSR sequence from SEED with round_idx
// counting up. A decrypt run starts at LAST_SEED (SEED after ROUNDS-1
// forward steps) and walks the inverse sequence with round_idx counting
// down. The two runs therefore produce exactly reversed constant streams.
// ---------------------------------------------------------------------------
module ublock_rc_gen
    import ublock_pkg::*;
#(
    parameter int           W      = DEF_W,
    parameter logic [W-1:0] TAPS   = W'(DEF_TAPS),
    parameter logic [W-1:0] SEED   = W'(DEF_SEED),
    parameter int           ROUNDS = DEF_ROUNDS
) (
    input  logic              clk,
    input  logic              rst,
    ublock_rc_gen_if.slave    bus
);

    localparam int              IDXW      = $clog2(ROUNDS);
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(ROUNDS - 1);
    localparam logic [W-1:0]    LAST_SEED =
        W'(lfsr_last_seed(64'(SEED), 64'(TAPS), ROUNDS - 1, W));

    rc_state_t       state_q, state_d;
    logic [W-1:0]    rc_q, rc_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            mode_q, mode_d;

    logic [W-1:0]    rc_step;
    logic            busy;
    logic            at_idx_lo;
    logic            at_idx_hi;
    logic            first_flag;
    logic            last_flag;

    // Only one step engine. Its direction comes from the latched mode, so
    // the decrypt input cannot change the direction partway through a run.
    lfsr_step #(
        .W    (W),
        .TAPS (TAPS)
    ) u_step (
        .state_i   (rc_q),
        .inverse_i (mode_q),
        .next_o    (rc_step)
    );

    // The position flags are decoded from the registered index and are
    // only valid while busy. A decrypt run starts at the top of the index
    // range, so the meaning of the two ends is swapped for that mode.
    assign busy       = (state_q == RUN);
    assign at_idx_lo  = (idx_q == '0);
    assign at_idx_hi  = (idx_q == LAST_IDX);
    assign first_flag = busy & (mode_q ? at_idx_hi : at_idx_lo);
    assign last_flag  = busy & (mode_q ? at_idx_lo : at_idx_hi);

    // Register the state. A low rst wins over every other input, including
    // in the middle of a run.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            rc_q    <= SEED;
            idx_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
        end
    end

    // Next-state logic for the sequencer. rc and round_idx hold in IDLE
    // and DONE, so the last constant stays visible after a run ends. An
    // advance that arrives together with start in IDLE is dropped: the
    // first constant must be presented for at least one cycle.
    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        idx_d   = idx_q;
        mode_d  = mode_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    mode_d  = bus.decrypt;
                    if (bus.decrypt) begin
                        rc_d  = LAST_SEED;
                        idx_d = LAST_IDX;
                    end else begin
                        rc_d  = SEED;
                        idx_d = '0;
                    end
                end
            end

            RUN: begin
                if (bus.advance) begin
                    if (last_flag) begin
                        state_d = DONE;
                    end else begin
                        rc_d  = rc_step;
                        idx_d = mode_q ? (idx_q - 1'b1) : (idx_q + 1'b1);
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.rc          = rc_q;
    assign bus.round_idx   = idx_q;
    assign bus.first_round = first_flag;
    assign bus.last_round  = last_flag;
    assign bus.busy        = busy;
    assign bus.done        = (state_q == DONE);

endmodule
